// File: rtl/ctrl_pkg.sv
// Shared encodings and pipeline control-word layouts for the ARM-subset pipeline controller.
// CTRL_UNDEF_TRAP_EN adds an undefined-encoding bit to the carried control words.
package ctrl_pkg;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_op_e;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // Control word held in the Decode->Execute register
   typedef struct packed {
      logic       reg_w;
      logic       mem_w;
      logic       mem_to_reg;
      logic       pcs;
      logic [1:0] flag_w;
      alu_op_e    alu_ctl;
      logic       alu_src;
      logic [3:0] cond;
`ifdef CTRL_UNDEF_TRAP_EN
      logic       undef;
`endif
   } ctrl_e_t;

   typedef struct packed {
      logic reg_w;
      logic mem_w;
      logic mem_to_reg;
      logic pcs;
`ifdef CTRL_UNDEF_TRAP_EN
      logic undef;
`endif
   } ctrl_m_t;

   typedef struct packed {
      logic reg_w;
      logic mem_to_reg;
      logic pcs;
   } ctrl_w_t;

   function automatic logic is_arith_cmd(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
   endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Controller <-> datapath bundle: decode instruction and ALU flags in, stage control bits out.
// CTRL_UNDEF_TRAP_EN adds the sticky UndefW status bit.
interface pipeline_controller_if;

   logic [31:0] InstrD;
   logic [3:0]  ALUFlags;
   logic        FlushE;
   logic [1:0]  RegSrcD;
   logic [1:0]  ImmSrcD;
   logic        ALUSrcE;
   logic [1:0]  ALUControlE;
   logic        MemWriteM;
   logic        RegWriteM;
   logic        MemtoRegE;
   logic        MemtoRegW;
   logic        RegWriteW;
   logic        PCSrcW;
   logic        PCWrPendingF;
`ifdef CTRL_UNDEF_TRAP_EN
   logic        UndefW;
`endif

   // Datapath side
   modport master (
      output InstrD, ALUFlags, FlushE,
      input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, RegWriteM,
             MemtoRegE, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF
`ifdef CTRL_UNDEF_TRAP_EN
      , input UndefW
`endif
   );

   // Controller side
   modport slave (
      input  InstrD, ALUFlags, FlushE,
      output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, RegWriteM,
             MemtoRegE, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF
`ifdef CTRL_UNDEF_TRAP_EN
      , output UndefW
`endif
   );

endinterface

// File: rtl/cond_unit.sv
// Execute-stage condition evaluation, {N,Z,C,V} flags register and condition gating of writes.
// CTRL_UNDEF_TRAP_EN adds gating of the undefined-encoding bit.
module cond_unit
   import ctrl_pkg::*;
#(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
`ifdef CTRL_UNDEF_TRAP_EN
   input  logic       undef,
   output logic       undef_g,
`endif
   input  logic [3:0] cond,
   input  logic [1:0] flag_w,
   input  logic [3:0] alu_flags,
   input  logic       reg_w,
   input  logic       mem_w,
   input  logic       pcs,
   output logic       reg_w_g,
   output logic       mem_w_g,
   output logic       pcs_g
);

   logic [3:0] flags;
   logic       cond_ex;

   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      {n, z, cf, v} = f;
      case (c)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_CS: r = cf;
         COND_CC: r = ~cf;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = cf & ~z;
         COND_LS: r = ~cf | z;
         COND_GE: r = ~(n ^ v);
         COND_LT: r = n ^ v;
         COND_GT: r = ~z & ~(n ^ v);
         COND_LE: r = z | (n ^ v);
         COND_AL: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // The instruction in Execute evaluates against flags committed by older instructions only
   assign cond_ex = cond_eval(cond, flags);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags <= FLAG_RESET;
      end else begin
         if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
         if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
      end
   end

   assign reg_w_g = reg_w & cond_ex;
   assign mem_w_g = mem_w & cond_ex;
   assign pcs_g   = pcs   & cond_ex;
`ifdef CTRL_UNDEF_TRAP_EN
   assign undef_g = undef & cond_ex;
`endif

endmodule

// File: rtl/pipeline_controller.sv
// ARM-subset pipeline control unit: Decode-stage decoder plus E/M/W control pipeline registers.
// Optional macro CTRL_UNDEF_TRAP_EN enables the sticky UndefW trap for unsupported encodings.
module pipeline_controller
   import ctrl_pkg::*;
#(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input logic clk,
   input logic reset,
   pipeline_controller_if.slave bus
);

   logic [3:0] cond_d;
   logic [1:0] op_d;
   logic [5:0] funct_d;
   logic [3:0] cmd_d;
   logic [3:0] rd_d;
   logic       s_eff_d;
   logic       arith_d;

   ctrl_e_t    ctrl_d;
   logic [1:0] reg_src_d;
   logic       branch_d;
   logic       cmd_ok;
   alu_op_e    alu_d;

   ctrl_e_t    ctrl_p0;
   ctrl_m_t    ctrl_p1;
   ctrl_w_t    ctrl_p2;

   logic       reg_w_g;
   logic       mem_w_g;
   logic       pcs_g;
`ifdef CTRL_UNDEF_TRAP_EN
   logic       undef_g;
   logic       undef_sticky;
`endif

   logic       unused_instr_bits;

   assign cond_d  = bus.InstrD[31:28];
   assign op_d    = bus.InstrD[27:26];
   assign funct_d = bus.InstrD[25:20];
   assign cmd_d   = funct_d[4:1];
   assign rd_d    = bus.InstrD[15:12];
   assign s_eff_d = funct_d[0] | (cmd_d == CMD_CMP);
   assign arith_d = is_arith_cmd(cmd_d);

   // Rn and the operand/offset fields belong to the datapath
   assign unused_instr_bits = ^{bus.InstrD[19:16], bus.InstrD[11:0]};

   // Decode stage
   always_comb begin
      ctrl_d      = '0;
      reg_src_d   = 2'b00;
      branch_d    = 1'b0;
      cmd_ok      = 1'b0;
      alu_d       = ALU_ADD;
      ctrl_d.cond = cond_d;
      case (op_d)
         OP_DP: begin
            case (cmd_d)
               CMD_ADD: begin alu_d = ALU_ADD; cmd_ok = 1'b1; end
               CMD_SUB: begin alu_d = ALU_SUB; cmd_ok = 1'b1; end
               CMD_CMP: begin alu_d = ALU_SUB; cmd_ok = 1'b1; end
               CMD_AND: begin alu_d = ALU_AND; cmd_ok = 1'b1; end
               CMD_ORR: begin alu_d = ALU_ORR; cmd_ok = 1'b1; end
               default: cmd_ok = 1'b0;
            endcase
            if (cmd_ok) begin
               ctrl_d.reg_w     = (cmd_d != CMD_CMP);
               ctrl_d.alu_src   = funct_d[5];
               ctrl_d.alu_ctl   = alu_d;
               ctrl_d.flag_w[1] = s_eff_d;
               ctrl_d.flag_w[0] = s_eff_d & arith_d;
            end
`ifdef CTRL_UNDEF_TRAP_EN
            else ctrl_d.undef = 1'b1;
`endif
         end
         OP_MEM: begin
            ctrl_d.alu_src = 1'b1;
            if (funct_d[0]) begin
               ctrl_d.mem_to_reg = 1'b1;
               ctrl_d.reg_w      = 1'b1;
            end else begin
               ctrl_d.mem_w = 1'b1;
               reg_src_d[1] = 1'b1;
            end
         end
         OP_BR: begin
            branch_d       = 1'b1;
            reg_src_d[0]   = 1'b1;
            ctrl_d.alu_src = 1'b1;
         end
         default: begin
`ifdef CTRL_UNDEF_TRAP_EN
            ctrl_d.undef = 1'b1;
`endif
         end
      endcase
      ctrl_d.pcs = branch_d | (ctrl_d.reg_w & (rd_d == 4'd15));
      // Reset forces every controller output low, including the combinational Decode ones
      if (reset) begin
         ctrl_d    = '0;
         reg_src_d = 2'b00;
      end
   end

   // Decode -> Execute
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           ctrl_p0 <= '0;
      else if (bus.FlushE) ctrl_p0 <= '0;
      else                 ctrl_p0 <= ctrl_d;
   end

   cond_unit #(
      .FLAG_RESET (FLAG_RESET)
   ) u_cond_unit (
      .clk       (clk),
      .reset     (reset),
`ifdef CTRL_UNDEF_TRAP_EN
      .undef     (ctrl_p0.undef),
      .undef_g   (undef_g),
`endif
      .cond      (ctrl_p0.cond),
      .flag_w    (ctrl_p0.flag_w),
      .alu_flags (bus.ALUFlags),
      .reg_w     (ctrl_p0.reg_w),
      .mem_w     (ctrl_p0.mem_w),
      .pcs       (ctrl_p0.pcs),
      .reg_w_g   (reg_w_g),
      .mem_w_g   (mem_w_g),
      .pcs_g     (pcs_g)
   );

   // Execute -> Memory
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_p1 <= '0;
      end else begin
         ctrl_p1.reg_w      <= reg_w_g;
         ctrl_p1.mem_w      <= mem_w_g;
         ctrl_p1.mem_to_reg <= ctrl_p0.mem_to_reg;
         ctrl_p1.pcs        <= pcs_g;
`ifdef CTRL_UNDEF_TRAP_EN
         ctrl_p1.undef      <= undef_g;
`endif
      end
   end

   // Memory -> Writeback
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_p2 <= '0;
      end else begin
         ctrl_p2.reg_w      <= ctrl_p1.reg_w;
         ctrl_p2.mem_to_reg <= ctrl_p1.mem_to_reg;
         ctrl_p2.pcs        <= ctrl_p1.pcs;
      end
   end

`ifdef CTRL_UNDEF_TRAP_EN
   // Writeback-stage undef bit, latched until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) undef_sticky <= 1'b0;
      else       undef_sticky <= undef_sticky | ctrl_p1.undef;
   end
   assign bus.UndefW = undef_sticky;
`endif

   assign bus.RegSrcD      = reg_src_d;
   assign bus.ImmSrcD      = reset ? 2'b00 : op_d;
   assign bus.ALUSrcE      = ctrl_p0.alu_src;
   assign bus.ALUControlE  = ctrl_p0.alu_ctl;
   assign bus.MemtoRegE    = ctrl_p0.mem_to_reg;
   assign bus.MemWriteM    = ctrl_p1.mem_w;
   assign bus.RegWriteM    = ctrl_p1.reg_w;
   assign bus.MemtoRegW    = ctrl_p2.mem_to_reg;
   assign bus.RegWriteW    = ctrl_p2.reg_w;
   assign bus.PCSrcW       = ctrl_p2.pcs;
   assign bus.PCWrPendingF = ctrl_d.pcs | ctrl_p0.pcs | ctrl_p1.pcs;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed program fragments plus random instruction streams
// checked every cycle against an instruction-level reference model.
module tb_pipeline_controller;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_controller_if bus ();

   pipeline_controller #(.FLAG_RESET(4'b0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   localparam logic [31:0] I_ADD  = 32'hE282_1005;
   localparam logic [31:0] I_ORR  = 32'hE382_1005;
   localparam logic [31:0] I_SUBS = 32'hE051_3001;
   localparam logic [31:0] I_CMP  = 32'hE151_0002;
   localparam logic [31:0] I_BEQ  = 32'h0A00_0002;
   localparam logic [31:0] I_BCS  = 32'h2A00_0000;
   localparam logic [31:0] I_LDR  = 32'hE590_4000;
   localparam logic [31:0] I_STR  = 32'hE580_4000;
   localparam logic [31:0] I_STRNE = 32'h1580_4000;
   localparam logic [31:0] I_NOP  = 32'hF000_0000;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       regw, memw, memtoreg, pcs, alusrc, undef;
      logic [1:0] flagw, aluctl, regsrc;
      logic [3:0] cond;
   } mctl_t;

   mctl_t      me, mm, mw;
   logic [3:0] mflags;
   logic       msticky;

   function automatic mctl_t ref_decode(input logic [31:0] ins);
      mctl_t c;
      logic [3:0] cmd;
      logic       s;
      c = '0;
      c.cond = ins[31:28];
      cmd = ins[24:21];
      s = ins[20];
      if (ins[27:26] == 2'b00) begin
         if (cmd == 4'b0100)      begin c.regw = 1; c.aluctl = 2'b00; c.flagw = {s, s}; end
         else if (cmd == 4'b0010) begin c.regw = 1; c.aluctl = 2'b01; c.flagw = {s, s}; end
         else if (cmd == 4'b1010) begin c.regw = 0; c.aluctl = 2'b01; c.flagw = 2'b11; end
         else if (cmd == 4'b0000) begin c.regw = 1; c.aluctl = 2'b10; c.flagw = {s, 1'b0}; end
         else if (cmd == 4'b1100) begin c.regw = 1; c.aluctl = 2'b11; c.flagw = {s, 1'b0}; end
         else c.undef = 1;
         if (!c.undef) c.alusrc = ins[25];
      end else if (ins[27:26] == 2'b01) begin
         c.alusrc = 1;
         if (ins[20]) begin c.regw = 1; c.memtoreg = 1; end
         else begin c.memw = 1; c.regsrc = 2'b10; end
      end else if (ins[27:26] == 2'b10) begin
         c.pcs = 1; c.regsrc = 2'b01; c.alusrc = 1;
      end else begin
         c.undef = 1;
      end
      if (c.regw && ins[15:12] == 4'hF) c.pcs = 1;
      return c;
   endfunction

   // ARM conditions come in complementary pairs: bit 0 inverts the even-code test
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      return c[0] ? !r : r;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      me = '0; mm = '0; mw = '0; mflags = 4'b0000; msticky = 1'b0;
   endtask

   task automatic model_edge();
      logic  ok;
      mctl_t nm;
      ok = cond_ok(me.cond, mflags);
      msticky = msticky | mm.undef;
      mw = mm;
      nm = me;
      nm.regw = me.regw & ok;
      nm.memw = me.memw & ok;
      nm.pcs = me.pcs & ok;
      nm.undef = me.undef & ok;
      if (me.flagw[1] && ok) mflags[3:2] = bus.ALUFlags[3:2];
      if (me.flagw[0] && ok) mflags[1:0] = bus.ALUFlags[1:0];
      mm = nm;
      me = bus.FlushE ? '0 : ref_decode(bus.InstrD);
   endtask

   task automatic check_all();
      mctl_t d;
      d = reset ? '0 : ref_decode(bus.InstrD);
      chk("RegSrcD", bus.RegSrcD, d.regsrc);
      chk("ImmSrcD", bus.ImmSrcD, reset ? 2'b00 : bus.InstrD[27:26]);
      chk("ALUSrcE", bus.ALUSrcE, me.alusrc);
      chk("ALUControlE", bus.ALUControlE, me.aluctl);
      chk("MemtoRegE", bus.MemtoRegE, me.memtoreg);
      chk("MemWriteM", bus.MemWriteM, mm.memw);
      chk("RegWriteM", bus.RegWriteM, mm.regw);
      chk("MemtoRegW", bus.MemtoRegW, mw.memtoreg);
      chk("RegWriteW", bus.RegWriteW, mw.regw);
      chk("PCSrcW", bus.PCSrcW, mw.pcs);
      chk("PCWrPendingF", bus.PCWrPendingF, d.pcs | me.pcs | mm.pcs);
`ifdef CTRL_UNDEF_TRAP_EN
      chk("UndefW", bus.UndefW, msticky);
`endif
   endtask

   task automatic step(input logic [31:0] ins, input logic [3:0] fl, input logic flush);
      bus.InstrD = ins;
      bus.ALUFlags = fl;
      bus.FlushE = flush;
      #2;
      check_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic mid_reset();
      bus.InstrD = I_BEQ;
      bus.FlushE = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_ALUSrcE", bus.ALUSrcE, 1'b0);
      chk("rst_ALUControlE", bus.ALUControlE, 2'b00);
      chk("rst_MemtoRegE", bus.MemtoRegE, 1'b0);
      chk("rst_MemWriteM", bus.MemWriteM, 1'b0);
      chk("rst_RegWriteM", bus.RegWriteM, 1'b0);
      chk("rst_RegWriteW", bus.RegWriteW, 1'b0);
      chk("rst_PCSrcW", bus.PCSrcW, 1'b0);
      chk("rst_PCWrPendingF", bus.PCWrPendingF, 1'b0);
      chk("rst_RegSrcD", bus.RegSrcD, 2'b00);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [3:0]  cond, cmd, rd;
      logic [5:0]  funct;
      logic [1:0]  op;
      int          kind;
      logic [3:0]  cmds [5];
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
      cond = ($urandom_range(0, 9) < 6) ? 4'b1110 : 4'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
         op = 2'b00;
         cmd = ($urandom_range(0, 4) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 4)];
         funct = {1'($urandom), cmd, 1'($urandom)};
      end else if (kind < 7) begin
         op = 2'b01;
         funct = 6'($urandom);
      end else if (kind < 9) begin
         op = 2'b10;
         funct = 6'($urandom);
      end else begin
         op = 2'b11;
         funct = 6'($urandom);
      end
      return {cond, op, funct, 4'($urandom), rd, 12'($urandom)};
   endfunction

   initial begin
      reset = 1'b1;
      bus.InstrD = I_ADD;
      bus.ALUFlags = 4'b0000;
      bus.FlushE = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;

      step(I_ADD, 4'b0000, 1'b0);
      chk("add_alusrc_e", bus.ALUSrcE, 1'b1);
      chk("add_aluctl_e", bus.ALUControlE, 2'b00);
      step(I_NOP, 4'b0000, 1'b0);
      step(I_NOP, 4'b0000, 1'b0);
      chk("add_regwrite_w", bus.RegWriteW, 1'b1);
      chk("add_memtoreg_w", bus.MemtoRegW, 1'b0);

      step(I_SUBS, 4'b0000, 1'b0);
      step(I_BEQ, 4'b0110, 1'b0);
      chk("beq_pending_e", bus.PCWrPendingF, 1'b1);
      step(I_NOP, 4'b0000, 1'b0);
      chk("beq_pending_m", bus.PCWrPendingF, 1'b1);
      step(I_NOP, 4'b0000, 1'b0);
      chk("beq_taken_w", bus.PCSrcW, 1'b1);

      step(I_CMP, 4'b0000, 1'b0);
      step(I_BEQ, 4'b0010, 1'b0);
      step(I_NOP, 4'b0000, 1'b0);
      step(I_NOP, 4'b0000, 1'b0);
      chk("beq_not_taken_w", bus.PCSrcW, 1'b0);
      step(I_BCS, 4'b0000, 1'b0);
      step(I_NOP, 4'b0000, 1'b0);
      step(I_NOP, 4'b0000, 1'b0);
      chk("bcs_after_cmp_w", bus.PCSrcW, 1'b1);

      step(I_LDR, 4'b0000, 1'b0);
      chk("ldr_memtoreg_e", bus.MemtoRegE, 1'b1);
      step(I_ORR, 4'b0000, 1'b1);
      chk("flush_alusrc_e", bus.ALUSrcE, 1'b0);
      chk("flush_aluctl_e", bus.ALUControlE, 2'b00);
      chk("flush_memtoreg_e", bus.MemtoRegE, 1'b0);

      step(I_STR, 4'b0000, 1'b0);
      chk("str_regsrc_d", bus.RegSrcD, 2'b10);
      step(I_NOP, 4'b0000, 1'b0);
      chk("str_memwrite_m", bus.MemWriteM, 1'b1);
      step(I_NOP, 4'b0000, 1'b0);
      chk("str_regwrite_w", bus.RegWriteW, 1'b0);
      step(I_SUBS, 4'b0000, 1'b0);
      step(I_STRNE, 4'b0100, 1'b0);
      step(I_NOP, 4'b0000, 1'b0);
      chk("strne_memwrite_m", bus.MemWriteM, 1'b0);

      step(I_ADD, 4'b0000, 1'b0);
      step(I_LDR, 4'b0000, 1'b0);
      step(I_BEQ, 4'b0000, 1'b0);
      mid_reset();
      for (int i = 0; i < 6; i++) step(I_BEQ, 4'b0000, 1'b0);

      for (int i = 0; i < 400; i++) begin
         step(rand_instr(), 4'($urandom), ($urandom_range(0, 9) == 0));
         if (i == 200) mid_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
